// File: rtl/smac_acc_drain_pkg.sv
// rtl/smac_acc_drain_pkg.sv - lane-mode encodings and helpers for the smac accumulate/drain stage
package smac_acc_drain_pkg;

    // One-hot select_precision encodings
    localparam logic [3:0] MODE_8  = 4'b0001;
    localparam logic [3:0] MODE_16 = 4'b0010;
    localparam logic [3:0] MODE_32 = 4'b0100;
    localparam logic [3:0] MODE_64 = 4'b1000;

    // Fixed lane map: 64-bit word, narrowest lane 8 bits, one sat flag per possible lane
    localparam int ACC_W      = 64;
    localparam int LANE_W_MIN = 8;
    localparam int SAT_W      = ACC_W / LANE_W_MIN;

    // Index into the per-mode adder results; value m means lanes of LANE_W_MIN << m bits
    typedef enum logic [1:0] {
        LM_8  = 2'd0,
        LM_16 = 2'd1,
        LM_32 = 2'd2,
        LM_64 = 2'd3
    } lane_mode_e;

    // Anything that is not a clean one-hot code falls back to a single 64-bit lane
    function automatic lane_mode_e decode_mode(input logic [3:0] sel);
        case (sel)
            MODE_8:  return LM_8;
            MODE_16: return LM_16;
            MODE_32: return LM_32;
            default: return LM_64;
        endcase
    endfunction

endpackage

// File: rtl/smac_drain_fifo.sv
// rtl/smac_drain_fifo.sv - first-word-fall-through output FIFO for finished tiles
module smac_drain_fifo
    import smac_acc_drain_pkg::*;
#(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_sclr_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal)
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO may still accept
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_empty = w_empty;
    assign o_full  = w_full;
    // Head is forced to zero while empty so stale storage never shows on the outputs
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; push into an empty FIFO becomes visible the following cycle
    always_ff @(posedge i_clk) begin
        if (!i_sclr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the head is gated by empty
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/smac_acc_drain.sv
// rtl/smac_acc_drain.sv - per-lane saturating tile accumulator feeding an output FIFO
module smac_acc_drain
    import smac_acc_drain_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_sclr_n,
    input  logic [3:0]        i_select_precision,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_k_len,
    input  logic              i_psum_valid,
    input  logic [DATA_W-1:0] i_psum,
    input  logic              i_psum_last,
    output logic              o_psum_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [SAT_W-1:0]  o_out_sat,
    output logic              o_busy,
    output logic              o_len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PUSH = 2'd2
    } state_e;

    state_e            r_state;
    lane_mode_e        r_mode;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [SAT_W-1:0]  r_sat;
    logic              r_psum_ready;
    logic              r_busy;
    logic              r_len_err;

    logic [3:0][ACC_W-1:0] w_lane_res;
    logic [3:0][SAT_W-1:0] w_lane_ovf;
    logic [DATA_W-1:0]     w_sum;
    logic [SAT_W-1:0]      w_ovf;
    logic                  w_accept;
    logic                  w_final;
    logic                  w_push;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_W+SAT_W-1:0] w_fifo_rdata;

    // Every lane width is computed in parallel; the latched mode picks one set.
    // Each lane adds in its own width, so no carry can leak into the neighbour.
    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int W = LANE_W_MIN << m;
        localparam int N = ACC_W / W;
        for (genvar l = 0; l < N; l++) begin : g_lane
            logic [W-1:0] w_a;
            logic [W-1:0] w_b;
            logic [W-1:0] w_s;
            logic         w_lovf;
            assign w_a    = r_acc[l*W +: W];
            assign w_b    = i_psum[l*W +: W];
            assign w_s    = w_a + w_b;
            // Signed overflow: operands agree in sign, result does not
            assign w_lovf = (w_a[W-1] == w_b[W-1]) && (w_s[W-1] != w_a[W-1]);
            // Clamp toward the operands' sign: 0111.. for positive, 1000.. for negative
            assign w_lane_res[m][l*W +: W] = w_lovf ? {w_a[W-1], {(W-1){~w_a[W-1]}}} : w_s;
            assign w_lane_ovf[m][l]        = w_lovf;
        end
        if (N < SAT_W) begin : g_pad
            assign w_lane_ovf[m][SAT_W-1:N] = '0;
        end
    end

    assign w_sum    = w_lane_res[r_mode];
    assign w_ovf    = w_lane_ovf[r_mode];
    assign w_accept = i_psum_valid && r_psum_ready;
    assign w_final  = (r_cnt == r_len - CNT_W'(1));
    // In PUSH the tile goes in when there is room, or when the head leaves on the same edge
    assign w_push   = (r_state == ST_PUSH) && (!w_fifo_full || i_out_ready);

    // Tile sequencing, accumulation and length checking
    always_ff @(posedge i_clk) begin
        if (!i_sclr_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= LM_64;
            r_len        <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_sat        <= '0;
            r_psum_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_ACC;
                        r_mode       <= decode_mode(i_select_precision);
                        r_len        <= (i_k_len == '0) ? CNT_W'(1) : i_k_len;
                        r_cnt        <= '0;
                        r_acc        <= '0;
                        r_sat        <= '0;
                        r_len_err    <= 1'b0;
                        r_psum_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_sat <= r_sat | w_ovf;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_final) begin
                            r_state      <= ST_PUSH;
                            r_psum_ready <= 1'b0;
                            if (!i_psum_last) begin
                                r_len_err <= 1'b1;
                            end
                        end else if (i_psum_last) begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    if (w_push) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_psum_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    smac_drain_fifo #(
        .WIDTH (DATA_W + SAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_sclr_n (i_sclr_n),
        .i_push   (w_push),
        .i_wdata  ({r_sat, r_acc}),
        .i_pop    (i_out_ready),
        .o_rdata  (w_fifo_rdata),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

    assign o_psum_ready = r_psum_ready;
    assign o_busy       = r_busy;
    assign o_len_err    = r_len_err;
    assign o_out_valid  = !w_fifo_empty;
    assign o_out_data   = w_fifo_rdata[DATA_W-1:0];
    assign o_out_sat    = w_fifo_rdata[DATA_W +: SAT_W];

endmodule
